// File: rtl/ama_riscv_wb_arbiter_if.sv
// Writeback arbiter bus bundle: primary/secondary writeback sources,
// scoreboard issue/check signals and the registered register file write port.
interface ama_riscv_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            p_we;
    logic [4:0]      p_addr;
    logic [XLEN-1:0] p_data;
    logic            s_valid;
    logic            s_ready;
    logic [4:0]      s_addr;
    logic [XLEN-1:0] s_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            hazard;
    logic            rf_we;
    logic [4:0]      rf_addr_d;
    logic [XLEN-1:0] rf_data_d;

    // Pipeline / decode side: drives requests, observes stall and RF port
    modport master (
        output p_we, p_addr, p_data,
        output s_valid, s_addr, s_data,
        output issue_valid, issue_rd,
        output chk_rs1, chk_rs2, chk_rd,
        input  s_ready, hazard,
        input  rf_we, rf_addr_d, rf_data_d
    );

    // Arbiter side
    modport slave (
        input  p_we, p_addr, p_data,
        input  s_valid, s_addr, s_data,
        input  issue_valid, issue_rd,
        input  chk_rs1, chk_rs2, chk_rd,
        output s_ready, hazard,
        output rf_we, rf_addr_d, rf_data_d
    );
endinterface

// File: rtl/ama_riscv_wb_arbiter.sv
// Writeback arbiter in front of the register file write port.
// Primary (in-order, no backpressure) wins; secondary (long-latency) results
// are buffered in a small FIFO or bypassed when the FIFO is empty.
// A scoreboard of pending long-latency destinations drives the decode stall.
module ama_riscv_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ama_riscv_wb_arbiter_if.slave wb
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 5 + XLEN;

    // FIFO storage and control
    logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Registered register file port; src_s marks a secondary-sourced write
    logic             rf_we_reg;
    logic [4:0]       rf_addr_d_reg;
    logic [XLEN-1:0]  rf_data_d_reg;
    logic             src_s_reg;

    // Scoreboard, bit 0 is never pending
    logic [31:1]      pend_reg;
    logic [31:0]      pend_full;

    logic             p_sel;
    logic             fifo_empty;
    logic             s_accept;
    logic             s_nonzero;
    logic             pop;
    logic             bypass;
    logic             push;
    logic [ENT_W-1:0] head;
    logic [4:0]       head_addr;
    logic [XLEN-1:0]  head_data;

    // Arbitration decode: primary > FIFO head > bypass
    always_comb begin
        p_sel      = wb.p_we && (wb.p_addr != 5'd0);
        fifo_empty = (count_reg == '0);
        wb.s_ready = (count_reg < CNT_W'(FIFO_DEPTH));
        s_accept   = wb.s_valid && wb.s_ready;
        s_nonzero  = (wb.s_addr != 5'd0);
        pop        = !p_sel && !fifo_empty;
        bypass     = !p_sel && fifo_empty && s_accept && s_nonzero;
        push       = s_accept && s_nonzero && !bypass;
        head       = mem_reg[rd_ptr_reg];
        head_addr  = head[ENT_W-1:XLEN];
        head_data  = head[XLEN-1:0];
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO payload write; contents need no reset since pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {wb.s_addr, wb.s_data};
        end
    end

    // FIFO pointers and count; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Register file write port; address/data hold when nothing is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg     <= 1'b0;
            rf_addr_d_reg <= 5'd0;
            rf_data_d_reg <= '0;
            src_s_reg     <= 1'b0;
        end else begin
            rf_we_reg <= p_sel || pop || bypass;
            src_s_reg <= pop || bypass;
            if (p_sel) begin
                rf_addr_d_reg <= wb.p_addr;
                rf_data_d_reg <= wb.p_data;
            end else if (pop) begin
                rf_addr_d_reg <= head_addr;
                rf_data_d_reg <= head_data;
            end else if (bypass) begin
                rf_addr_d_reg <= wb.s_addr;
                rf_data_d_reg <= wb.s_data;
            end
        end
    end

    // Scoreboard bits: clear when the RF commits a secondary write, set on issue (set wins)
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pend
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_reg[gi] <= 1'b0;
                end else if (wb.issue_valid && (wb.issue_rd == 5'(gi))) begin
                    pend_reg[gi] <= 1'b1;
                end else if (rf_we_reg && src_s_reg && (rf_addr_d_reg == 5'(gi))) begin
                    pend_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Hazard lookup on the decode operands
    always_comb begin
        pend_full = {pend_reg, 1'b0};
        wb.hazard = pend_full[wb.chk_rs1] | pend_full[wb.chk_rs2] | pend_full[wb.chk_rd];
    end

    assign wb.rf_we     = rf_we_reg;
    assign wb.rf_addr_d = rf_addr_d_reg;
    assign wb.rf_data_d = rf_data_d_reg;

    // Primary must never overwrite a register still owned by a long-latency op
    a_no_primary_on_pending: assert property (
        @(posedge clk) disable iff (!rst_n) !(p_sel && pend_full[wb.p_addr])
    );
endmodule
